// File: rtl/fft_pkg.sv
// Shared FFT definitions: transform size, sample width, the packed bin type and
// the address bit-reversal helper used by the loader, core and result reader.
package fft_pkg;

  localparam int N_PT = 8;
  localparam int DW   = 24;
  localparam int AW   = $clog2(N_PT);

  typedef struct packed {
    logic signed [DW-1:0] re;
    logic signed [DW-1:0] im;
    logic [AW-1:0]        idx;
  } bin_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  function automatic logic [AW-1:0] bitrev(input logic [AW-1:0] a);
    logic [AW-1:0] r;
    for (int i = 0; i < AW; i++) begin
      r[i] = a[AW-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_result_reader_if.sv
// Output bin stream of the FFT result reader: valid/ready handshake plus the
// bin payload (real, imaginary, logical index, end-of-frame marker).
interface fft_result_reader_if;

  logic                         out_valid;
  logic                         out_ready;
  logic signed [fft_pkg::DW-1:0] out_re;
  logic signed [fft_pkg::DW-1:0] out_im;
  logic [fft_pkg::AW-1:0]       out_idx;
  logic                         out_last;

  modport master (
    output out_valid, out_re, out_im, out_idx, out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_re, out_im, out_idx, out_last,
    output out_ready
  );

endinterface

// File: rtl/fft_bin_fifo.sv
// Synchronous first-word-fall-through FIFO of FFT bins with registered head
// outputs; accepts a push and a pop in the same cycle even when full.
module fft_bin_fifo
  import fft_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  bin_t          wr_data,
  input  logic          rd_en,
  output bin_t          rd_data,
  output logic          rd_valid,
  output logic [CW-1:0] count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] PTR_MAX = PW'(DEPTH - 1);

  bin_t          r_mem [DEPTH];
  bin_t          r_head;
  logic          r_valid;
  logic [PW-1:0] r_wr_ptr, r_rd_ptr, w_rd_next;
  logic [CW-1:0] r_count, w_left, w_count_next;
  logic          w_push, w_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PTR_MAX) ? '0 : p + PW'(1);
  endfunction

  assign w_pop        = rd_en && (r_count != '0);
  assign w_left       = r_count - CW'(w_pop);
  assign w_push       = wr_en && (w_left < CW'(DEPTH));
  assign w_count_next = w_left + CW'(w_push);
  assign w_rd_next    = w_pop ? ptr_inc(r_rd_ptr) : r_rd_ptr;

  // Bin storage, written at the tail pointer
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= wr_data;
    end
  end

  // Pointers, occupancy and the registered head; an empty-after-pop FIFO takes the incoming bin directly
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_valid  <= 1'b0;
      r_head   <= '0;
    end else begin
      r_count  <= w_count_next;
      r_rd_ptr <= w_rd_next;
      r_valid  <= (w_count_next != '0);
      if (w_push) begin
        r_wr_ptr <= ptr_inc(r_wr_ptr);
      end
      if (w_count_next != '0) begin
        r_head <= (w_left == '0) ? wr_data : r_mem[w_rd_next];
      end
    end
  end

  assign rd_data  = r_head;
  assign rd_valid = r_valid;
  assign count    = r_count;

endmodule

// File: rtl/fft_result_reader.sv
// Unloads the FFT result RAM after each transform and streams the bins out,
// in natural or bit-reversed address order, under consumer back-pressure.
module fft_result_reader
  import fft_pkg::*;
#(
  parameter int RD_LAT     = 1,
  parameter int BITREV     = 0,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 fft_finish,
  output logic [AW-1:0]        read_addr,
  input  logic signed [DW-1:0] dataout_re,
  input  logic signed [DW-1:0] dataout_im,
  fft_result_reader_if.master  out,
  output logic                 busy,
  output logic                 drop_err
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [AW-1:0] LAST_IDX = AW'(N_PT - 1);

  function automatic logic [AW-1:0] phys_addr(input logic [AW-1:0] k);
    return (BITREV != 0) ? bitrev(k) : k;
  endfunction

  state_t        r_state, w_next;
  logic          r_fin, r_busy, r_drop;
  logic [AW-1:0] r_icnt, r_addr;
  logic          w_start, w_space, w_issue, w_tag_v, w_tag_empty, w_pop, w_fifo_done;
  logic [AW-1:0] w_tag_idx;
  logic [7:0]    w_inflight, w_occ;
  logic [CW-1:0] w_fifo_count;
  logic          w_head_v;
  bin_t          w_wr_bin, w_head;

  assign w_start     = fft_finish & ~r_fin;
  // Every issued read must already own a FIFO slot, so the FIFO can never overflow
  assign w_occ       = 8'(w_fifo_count) + w_inflight;
  assign w_space     = (w_occ < 8'(FIFO_DEPTH));
  assign w_issue     = (r_state == ST_ISSUE) && w_space;
  assign w_tag_empty = (w_inflight == 8'd0);

  generate
    if (RD_LAT == 0) begin : g_lat0
      assign w_tag_v    = w_issue;
      assign w_tag_idx  = r_icnt;
      assign w_inflight = 8'd0;
    end else begin : g_pipe
      logic [RD_LAT-1:0] r_tv;
      logic [AW-1:0]     r_tidx [RD_LAT];

      // Tag pipeline tracking each outstanding read and its logical index
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          r_tv <= '0;
          for (int i = 0; i < RD_LAT; i++) begin
            r_tidx[i] <= '0;
          end
        end else begin
          r_tv[0]   <= w_issue;
          r_tidx[0] <= r_icnt;
          for (int i = 1; i < RD_LAT; i++) begin
            r_tv[i]   <= r_tv[i-1];
            r_tidx[i] <= r_tidx[i-1];
          end
        end
      end

      assign w_tag_v    = r_tv[RD_LAT-1];
      assign w_tag_idx  = r_tidx[RD_LAT-1];
      assign w_inflight = 8'($countones(r_tv));
    end
  endgenerate

  assign w_wr_bin = '{re: dataout_re, im: dataout_im, idx: w_tag_idx};
  assign w_pop    = w_head_v & out.out_ready;
  // The frame is complete when the FIFO is empty or its final bin leaves this cycle
  assign w_fifo_done = (w_fifo_count == '0) ||
                       ((w_fifo_count == CW'(1)) && w_pop && !w_tag_v);

  fft_bin_fifo #(
    .DEPTH (FIFO_DEPTH),
    .CW    (CW)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (w_tag_v),
    .wr_data  (w_wr_bin),
    .rd_en    (w_pop),
    .rd_data  (w_head),
    .rd_valid (w_head_v),
    .count    (w_fifo_count)
  );

  // Next-state logic of the unload sequencer
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_start) w_next = ST_ISSUE;
        else         w_next = ST_IDLE;
      end
      ST_ISSUE: begin
        if (w_issue && (r_icnt == LAST_IDX)) w_next = ST_DRAIN;
        else                                 w_next = ST_ISSUE;
      end
      ST_DRAIN: begin
        if (w_tag_empty && w_fifo_done) w_next = ST_IDLE;
        else                            w_next = ST_DRAIN;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // State register, start edge detector, address counter and status flags
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_fin   <= 1'b0;
      r_busy  <= 1'b0;
      r_drop  <= 1'b0;
      r_icnt  <= '0;
      r_addr  <= '0;
    end else begin
      r_state <= w_next;
      r_fin   <= fft_finish;
      r_busy  <= (w_next != ST_IDLE);
      if (w_start && (r_state != ST_IDLE)) begin
        r_drop <= 1'b1;
      end
      case (r_state)
        ST_IDLE: begin
          r_icnt <= '0;
          r_addr <= '0;
        end
        ST_ISSUE: begin
          if (w_issue && (r_icnt != LAST_IDX)) begin
            r_icnt <= r_icnt + AW'(1);
            r_addr <= phys_addr(r_icnt + AW'(1));
          end
        end
        ST_DRAIN: begin
          if (w_next == ST_IDLE) r_addr <= '0;
        end
        default: r_addr <= '0;
      endcase
    end
  end

  assign read_addr     = r_addr;
  assign busy          = r_busy;
  assign drop_err      = r_drop;
  assign out.out_valid = w_head_v;
  assign out.out_re    = w_head.re;
  assign out.out_im    = w_head.im;
  assign out.out_idx   = w_head.idx;
  assign out.out_last  = (w_head.idx == LAST_IDX);

endmodule
